// File: rtl/csi_pkg.sv
// csi_pkg: shared constants, data types and header layout for the CSI-2 packet parser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package csi_pkg;

    // CSI-2 data identifiers (lower 6 bits of DI)
    typedef enum logic [5:0] {
        DT_FRAME_START     = 6'h00,
        DT_FRAME_END       = 6'h01,
        DT_LINE_START      = 6'h02,
        DT_LINE_END        = 6'h03,
        DT_GENERIC_SHORT_1 = 6'h08,
        DT_GENERIC_SHORT_8 = 6'h0F,
        DT_NULL            = 6'h10,
        DT_BLANKING        = 6'h11,
        DT_EMBEDDED        = 6'h12,
        DT_YUV422_8        = 6'h1E,
        DT_RGB888          = 6'h24,
        DT_RAW6            = 6'h28,
        DT_RAW7            = 6'h29,
        DT_RAW8            = 6'h2A,
        DT_RAW10           = 6'h2B,
        DT_RAW12           = 6'h2C,
        DT_RAW14           = 6'h2D
    } data_type_t;

    // Any DT at or below this value is a 4-byte short packet
    localparam logic [5:0]  SHORT_PACKET_MAX_DT = 6'h0F;

    // CRC-16-CCITT, processed LSB first, so the polynomial is used bit-reflected
    localparam logic [15:0] CRC_SEED           = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFLECTED = 16'h8408;

    // Parser FSM state encoding
    localparam logic [1:0]  ST_HEADER   = 2'd0;
    localparam logic [1:0]  ST_PAYLOAD  = 2'd1;
    localparam logic [1:0]  ST_CHECKSUM = 2'd2;
    localparam logic [1:0]  ST_DONE     = 2'd3;

    // Held header fields as presented on the outputs
    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } csi_header_t;

    // Advance the CRC register by one byte, LSB of the byte first
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFLECTED;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/csi_crc16.sv
// csi_crc16: byte-wide CRC-16-CCITT accumulator (LSB-first, no final XOR).
// Latency: register updates on the enabling edge; crc output is the register itself.
// Backpressure: none; enable gates accumulation, seed overrides enable.
module csi_crc16
    import csi_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  data,
    input  logic        enable,
    input  logic        seed,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    // Seed takes priority so a new packet always starts from a clean register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC_SEED;
        end else if (seed) begin
            crc_q <= CRC_SEED;
        end else if (enable) begin
            crc_q <= crc16_next(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/csi_packet_parser.sv
// csi_packet_parser: CSI-2 header parse, payload forward, CRC-16 footer check and PHY re-arm.
// Latency: all outputs registered, 1 cycle after the enabling byte; packet_done 2 cycles after last CRC byte.
// Backpressure: none; up to 1 byte/cycle, phy_enable gaps stall the FSM. CRC check built only with CSI_CRC_CHECK_EN.
module csi_packet_parser
    import csi_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  phy_data,
    input  logic        phy_enable,
    output logic        phy_reset,
    output logic        header_valid,
    output logic [1:0]  virtual_channel,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic [7:0]  header_ecc,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        packet_done,
    output logic        crc_error
);

    logic [1:0]  state_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  di_q;
    logic [7:0]  wc_lo_q;
    logic [7:0]  wc_hi_q;
    logic [15:0] wc_cnt_q;
    logic        ck_idx_q;
    csi_header_t hdr_q;

    logic        header_last;
    logic        is_short;
    logic [15:0] hdr_wc;

    // ECC byte arriving: the first three header bytes are already in di/wc registers
    assign header_last = (state_q == ST_HEADER) && phy_enable && (byte_cnt_q == 2'd3);
    assign is_short    = (di_q[5:0] <= SHORT_PACKET_MAX_DT);
    assign hdr_wc      = {wc_hi_q, wc_lo_q};

    assign virtual_channel = hdr_q.vc;
    assign data_type       = hdr_q.dt;
    assign word_count      = hdr_q.wc;
    assign header_ecc      = hdr_q.ecc;

    // Packet FSM: header capture, payload forwarding, checksum consumption, one-cycle PHY re-arm
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HEADER;
            byte_cnt_q    <= 2'd0;
            di_q          <= 8'd0;
            wc_lo_q       <= 8'd0;
            wc_hi_q       <= 8'd0;
            wc_cnt_q      <= 16'd0;
            ck_idx_q      <= 1'b0;
            hdr_q         <= '0;
            header_valid  <= 1'b0;
            payload_data  <= 8'd0;
            payload_valid <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            packet_done   <= 1'b0;
            phy_reset     <= 1'b0;
        end else begin
            header_valid  <= 1'b0;
            payload_valid <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            packet_done   <= 1'b0;
            phy_reset     <= 1'b0;

            case (state_q)
                ST_HEADER: begin
                    if (phy_enable) begin
                        case (byte_cnt_q)
                            2'd0: di_q    <= phy_data;
                            2'd1: wc_lo_q <= phy_data;
                            2'd2: wc_hi_q <= phy_data;
                            default: begin
                                hdr_q.vc     <= di_q[7:6];
                                hdr_q.dt     <= di_q[5:0];
                                hdr_q.wc     <= hdr_wc;
                                hdr_q.ecc    <= phy_data;
                                header_valid <= 1'b1;
                            end
                        endcase

                        if (header_last) begin
                            byte_cnt_q <= 2'd0;
                            if (is_short) begin
                                state_q <= ST_DONE;
                                case (di_q[5:0])
                                    DT_FRAME_START: frame_start <= 1'b1;
                                    DT_FRAME_END:   frame_end   <= 1'b1;
                                    DT_LINE_START:  line_start  <= 1'b1;
                                    DT_LINE_END:    line_end    <= 1'b1;
                                    default: ;
                                endcase
                            end else if (hdr_wc == 16'd0) begin
                                state_q <= ST_CHECKSUM;
                            end else begin
                                state_q  <= ST_PAYLOAD;
                                wc_cnt_q <= hdr_wc;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (phy_enable) begin
                        payload_data  <= phy_data;
                        payload_valid <= 1'b1;
                        // Leave on the last byte instead of decrementing to zero
                        if (wc_cnt_q == 16'd1) begin
                            wc_cnt_q <= 16'd0;
                            state_q  <= ST_CHECKSUM;
                        end else begin
                            wc_cnt_q <= wc_cnt_q - 16'd1;
                        end
                    end
                end

                ST_CHECKSUM: begin
                    if (phy_enable) begin
                        if (ck_idx_q) begin
                            ck_idx_q <= 1'b0;
                            state_q  <= ST_DONE;
                        end else begin
                            ck_idx_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    // DONE: exactly one cycle, any byte presented now is dropped
                    packet_done <= 1'b1;
                    phy_reset   <= 1'b1;
                    state_q     <= ST_HEADER;
                end
            endcase
        end
    end

`ifdef CSI_CRC_CHECK_EN
    logic [15:0] crc_value;
    logic [7:0]  crc_lo_q;
    logic        crc_bad_q;
    logic        crc_seed;
    logic        crc_feed;

    // Reseed when a long header completes so zero-length packets compare against the seed
    assign crc_seed = header_last && !is_short;
    assign crc_feed = (state_q == ST_PAYLOAD) && phy_enable;

    csi_crc16 u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .data    (phy_data),
        .enable  (crc_feed),
        .seed    (crc_seed),
        .crc     (crc_value)
    );

    // Keep the received CRC low byte, then latch the verdict until DONE reports it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_lo_q  <= 8'd0;
            crc_bad_q <= 1'b0;
        end else if ((state_q == ST_CHECKSUM) && phy_enable) begin
            if (ck_idx_q) begin
                crc_bad_q <= (crc_value != {phy_data, crc_lo_q});
            end else begin
                crc_lo_q <= phy_data;
            end
        end else if (state_q == ST_DONE) begin
            crc_bad_q <= 1'b0;
        end
    end

    // crc_error pulses in the same cycle as packet_done
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_error <= 1'b0;
        end else begin
            crc_error <= (state_q == ST_DONE) && crc_bad_q;
        end
    end
`else
    assign crc_error = 1'b0;
`endif

endmodule
